// File: rtl/uv_risc_pkg.sv
// Shared uv-risc definitions: default register-file geometry, select type and flag bit indices.
package uv_risc_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_FLAGSW = 4;
  localparam int DEF_SELW   = $clog2(DEF_NREGS);

  typedef logic [DEF_SELW-1:0] reg_sel_t;

  localparam int Z = 0;
  localparam int N = 1;
  localparam int C = 2;
  localparam int V = 3;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by an accepted issue, cleared by writeback.
module regfile_scoreboard
  import uv_risc_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid_i,
  input  logic [SELW-1:0]  iss_sel_i,
  input  logic [NREGS-1:0] clr_vec_i,
  input  logic [SELW-1:0]  rd1_sel_i,
  input  logic [SELW-1:0]  rd2_sel_i,
  output logic [NREGS-1:0] busy_vec_o,
  output logic             busy1_o,
  output logic             busy2_o,
  output logic             iss_ready_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  assign iss_ready_o = !busy_q[iss_sel_i] || (iss_sel_i == '0);

  // The set is applied after the clear so a same-cycle reissue stays pending.
  always_comb begin
    busy_d = busy_q & ~clr_vec_i;
    if (iss_valid_i && iss_ready_o) begin
      busy_d[iss_sel_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign busy1_o    = busy_q[rd1_sel_i];
  assign busy2_o    = busy_q[rd2_sel_i];

endmodule

// File: rtl/regfile_scb.sv
// uv-risc register unit with R0 hard-wired zero, HI write port, flags and pending-write scoreboard.
// Build option REGFILE_BYPASS_EN: same-cycle writes are forwarded to the read ports and flags output.
module regfile_scb
  import uv_risc_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int FLAGSW = DEF_FLAGSW,
  parameter  int HI_REG = 1,
  localparam int SELW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_we,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              hi_we,
  input  logic [WIDTH-1:0]  hi_in,
  input  logic              flags_we,
  input  logic [FLAGSW-1:0] flags_in,
  input  logic [SELW-1:0]   rd1_sel,
  input  logic [SELW-1:0]   rd2_sel,
  output logic [WIDTH-1:0]  data1,
  output logic [WIDTH-1:0]  data2,
  output logic              busy1,
  output logic              busy2,
  output logic [FLAGSW-1:0] flags,
  input  logic              iss_valid,
  input  logic [SELW-1:0]   iss_sel,
  output logic              iss_ready,
  output logic [NREGS-1:0]  busy_vec
);

  localparam logic [SELW-1:0] HI_SEL = SELW'(HI_REG);

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  logic [FLAGSW-1:0] flags_q;
  logic [NREGS-1:0]  clr_vec;
  logic              sb_busy1, sb_busy2;

  // Data port is applied last so it wins a collision with the hi port.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i]  = regs_q[i];
      clr_vec[i] = 1'b0;
      if (hi_we && (HI_SEL == SELW'(i))) begin
        regs_d[i]  = hi_in;
        clr_vec[i] = 1'b1;
      end
      if (reg_we && (wr_sel == SELW'(i))) begin
        regs_d[i]  = data_in;
        clr_vec[i] = 1'b1;
      end
    end
    regs_d[0]  = '0;
    clr_vec[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      if (flags_we) begin
        flags_q <= flags_in;
      end
    end
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_scb (
    .clk         (clk),
    .reset       (reset),
    .iss_valid_i (iss_valid),
    .iss_sel_i   (iss_sel),
    .clr_vec_i   (clr_vec),
    .rd1_sel_i   (rd1_sel),
    .rd2_sel_i   (rd2_sel),
    .busy_vec_o  (busy_vec),
    .busy1_o     (sb_busy1),
    .busy2_o     (sb_busy2),
    .iss_ready_o (iss_ready)
  );

`ifdef REGFILE_BYPASS_EN
  // regs_d already carries the prioritised same-cycle write and a zero R0.
  assign data1 = regs_d[rd1_sel];
  assign data2 = regs_d[rd2_sel];
  assign busy1 = sb_busy1 && !clr_vec[rd1_sel];
  assign busy2 = sb_busy2 && !clr_vec[rd2_sel];
  assign flags = flags_we ? flags_in : flags_q;
`else
  assign data1 = regs_q[rd1_sel];
  assign data2 = regs_q[rd2_sel];
  assign busy1 = sb_busy1;
  assign busy2 = sb_busy2;
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_regfile_scb.sv
// Self-checking bench for regfile_scb: directed vector table followed by randomized traffic vs a reference model.
module tb_regfile_scb;
  import uv_risc_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int HI = 1;
  localparam int NV = 22;

  logic        clk;
  logic        reset;
  logic        reg_we;
  logic [2:0]  wr_sel;
  logic [15:0] data_in;
  logic        hi_we;
  logic [15:0] hi_in;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic [2:0]  rd1_sel, rd2_sel;
  logic [15:0] data1, data2;
  logic        busy1, busy2;
  logic [3:0]  flags;
  logic        iss_valid;
  logic [2:0]  iss_sel;
  logic        iss_ready;
  logic [7:0]  busy_vec;

  regfile_scb #(.WIDTH(16), .NREGS(8), .FLAGSW(4), .HI_REG(HI)) dut (
    .clk(clk), .reset(reset),
    .reg_we(reg_we), .wr_sel(wr_sel), .data_in(data_in),
    .hi_we(hi_we), .hi_in(hi_in),
    .flags_we(flags_we), .flags_in(flags_in),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .data1(data1), .data2(data2), .busy1(busy1), .busy2(busy2),
    .flags(flags),
    .iss_valid(iss_valid), .iss_sel(iss_sel), .iss_ready(iss_ready),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rwe;
    logic [2:0]  wsel;
    logic [15:0] din;
    logic        hwe;
    logic [15:0] hin;
    logic        fwe;
    logic [3:0]  fin;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        iv;
    logic [2:0]  isel;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic [7:0]  e_bv;
    logic        e_rdy;
    logic [3:0]  e_fl;
  } vec_t;

  vec_t vecs [NV];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  logic [7:0]  m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset     = v.rst_n;
    reg_we    = v.rwe;
    wr_sel    = v.wsel;
    data_in   = v.din;
    hi_we     = v.hwe;
    hi_in     = v.hin;
    flags_we  = v.fwe;
    flags_in  = v.fin;
    rd1_sel   = v.r1;
    rd2_sel   = v.r2;
    iss_valid = v.iv;
    iss_sel   = v.isel;
  endtask

  function automatic bit hits(input logic [2:0] sel);
    return (reg_we && wr_sel == sel) || (hi_we && sel == 3'(HI));
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] sel);
    if (sel == 0) return 16'h0;
    if (BYP && reg_we && wr_sel == sel) return data_in;
    if (BYP && hi_we && sel == 3'(HI)) return hi_in;
    return m_regs[sel];
  endfunction

  function automatic logic m_busy_rd(input logic [2:0] sel);
    if (sel == 0) return 1'b0;
    return m_busy[sel] && !(BYP && hits(sel));
  endfunction

  task automatic check_model(input int cyc);
    logic ready_exp;
    ready_exp = (iss_sel == 0) || !m_busy[iss_sel];
    chk($sformatf("rnd%0d data1", cyc), 32'(data1), 32'(m_read(rd1_sel)));
    chk($sformatf("rnd%0d data2", cyc), 32'(data2), 32'(m_read(rd2_sel)));
    chk($sformatf("rnd%0d busy1", cyc), 32'(busy1), 32'(m_busy_rd(rd1_sel)));
    chk($sformatf("rnd%0d busy2", cyc), 32'(busy2), 32'(m_busy_rd(rd2_sel)));
    chk($sformatf("rnd%0d busy_vec", cyc), 32'(busy_vec), 32'(m_busy));
    chk($sformatf("rnd%0d iss_ready", cyc), 32'(iss_ready), 32'(ready_exp));
    chk($sformatf("rnd%0d flags", cyc), 32'(flags), 32'((BYP && flags_we) ? flags_in : m_flags));
  endtask

  task automatic update_model();
    logic accept;
    accept = iss_valid && ((iss_sel == 0) || !m_busy[iss_sel]);
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_flags = 4'h0;
      m_busy  = 8'h0;
    end else begin
      if (hi_we) begin
        m_regs[HI] = hi_in;
        m_busy[HI] = 1'b0;
      end
      if (reg_we && wr_sel != 0) begin
        m_regs[wr_sel] = data_in;
        m_busy[wr_sel] = 1'b0;
      end
      if (accept && iss_sel != 0) m_busy[iss_sel] = 1'b1;
      if (flags_we) m_flags = flags_in;
    end
  endtask

  initial begin
    vecs[0]  = '{0,1,3,16'hBEEF,0,0,1,4'hF,3,0,1,2, (BYP ? 16'hBEEF : 16'h0),0,0,0,8'h00,1,(BYP ? 4'hF : 4'h0)};
    vecs[1]  = '{1,0,0,0,0,0,0,0,3,2,0,0, 16'h0,16'h0,0,0,8'h00,1,4'h0};
    vecs[2]  = '{1,1,3,16'hBEEF,0,0,0,0,3,0,0,0, (BYP ? 16'hBEEF : 16'h0),16'h0,0,0,8'h00,1,4'h0};
    vecs[3]  = '{1,0,0,0,0,0,0,0,3,0,0,0, 16'hBEEF,16'h0,0,0,8'h00,1,4'h0};
    vecs[4]  = '{1,1,0,16'h1234,0,0,0,0,0,3,0,0, 16'h0,16'hBEEF,0,0,8'h00,1,4'h0};
    vecs[5]  = '{1,0,0,0,0,0,0,0,0,3,1,0, 16'h0,16'hBEEF,0,0,8'h00,1,4'h0};
    vecs[6]  = '{1,0,0,0,0,0,0,0,0,0,0,0, 16'h0,16'h0,0,0,8'h00,1,4'h0};
    vecs[7]  = '{1,1,1,16'h00AA,1,16'h00BB,0,0,1,0,0,0, (BYP ? 16'h00AA : 16'h0),16'h0,0,0,8'h00,1,4'h0};
    vecs[8]  = '{1,0,0,0,0,0,0,0,1,0,0,0, 16'h00AA,16'h0,0,0,8'h00,1,4'h0};
    vecs[9]  = '{1,1,2,16'h00AA,1,16'h00BB,0,0,1,2,0,0, (BYP ? 16'h00BB : 16'h00AA),(BYP ? 16'h00AA : 16'h0),0,0,8'h00,1,4'h0};
    vecs[10] = '{1,0,0,0,0,0,0,0,1,2,0,0, 16'h00BB,16'h00AA,0,0,8'h00,1,4'h0};
    vecs[11] = '{1,0,0,0,0,0,0,0,0,5,1,5, 16'h0,16'h0,0,0,8'h00,1,4'h0};
    vecs[12] = '{1,0,0,0,0,0,0,0,0,5,1,5, 16'h0,16'h0,0,1,8'h20,0,4'h0};
    vecs[13] = '{1,1,5,16'h0F0F,0,0,0,0,0,5,0,5, 16'h0,(BYP ? 16'h0F0F : 16'h0),0,(BYP ? 1'b0 : 1'b1),8'h20,0,4'h0};
    vecs[14] = '{1,1,5,16'h1111,0,0,0,0,5,5,1,5, (BYP ? 16'h1111 : 16'h0F0F),(BYP ? 16'h1111 : 16'h0F0F),0,0,8'h00,1,4'h0};
    vecs[15] = '{1,0,0,0,0,0,0,0,0,5,0,5, 16'h0,16'h1111,0,1,8'h20,0,4'h0};
    vecs[16] = '{1,1,4,16'h5555,0,0,1,4'h5,4,0,0,0, (BYP ? 16'h5555 : 16'h0),16'h0,0,0,8'h20,1,(BYP ? 4'h5 : 4'h0)};
    vecs[17] = '{1,0,0,0,0,0,0,0,4,0,0,0, 16'h5555,16'h0,0,0,8'h20,1,4'h5};
    vecs[18] = '{1,0,0,0,0,0,0,0,6,0,1,6, 16'h0,16'h0,0,0,8'h20,1,4'h5};
    vecs[19] = '{0,0,0,0,1,16'h7777,0,0,6,4,0,6, 16'h0,16'h5555,1,0,8'h60,0,4'h5};
    vecs[20] = '{1,1,6,16'h3333,0,0,0,0,6,4,0,6, (BYP ? 16'h3333 : 16'h0),16'h0,0,0,8'h00,1,4'h0};
    vecs[21] = '{1,0,0,0,0,0,0,0,6,1,0,0, 16'h3333,16'h0,0,0,8'h00,1,4'h0};

    apply('{0,0,0,0,0,0,0,0,0,0,0,0, 16'h0,16'h0,0,0,8'h0,0,4'h0});
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k]);
      #1;
      chk($sformatf("vec%0d data1", k), 32'(data1), 32'(vecs[k].e_d1));
      chk($sformatf("vec%0d data2", k), 32'(data2), 32'(vecs[k].e_d2));
      chk($sformatf("vec%0d busy1", k), 32'(busy1), 32'(vecs[k].e_b1));
      chk($sformatf("vec%0d busy2", k), 32'(busy2), 32'(vecs[k].e_b2));
      chk($sformatf("vec%0d busy_vec", k), 32'(busy_vec), 32'(vecs[k].e_bv));
      chk($sformatf("vec%0d iss_ready", k), 32'(iss_ready), 32'(vecs[k].e_rdy));
      chk($sformatf("vec%0d flags", k), 32'(flags), 32'(vecs[k].e_fl));
      @(posedge clk);
      @(negedge clk);
    end

    for (int c = 0; c < 800; c++) begin
      reset     = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      reg_we    = ($urandom_range(0, 2) == 0);
      wr_sel    = 3'($urandom_range(0, 7));
      data_in   = 16'($urandom);
      hi_we     = ($urandom_range(0, 3) == 0);
      hi_in     = 16'($urandom);
      flags_we  = ($urandom_range(0, 3) == 0);
      flags_in  = 4'($urandom);
      rd1_sel   = 3'($urandom_range(0, 7));
      rd2_sel   = 3'($urandom_range(0, 7));
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_sel   = 3'($urandom_range(0, 7));
      #1;
      if (c != 0) check_model(c);
      @(posedge clk);
      update_model();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
